// File: rtl/regfile_read_arbiter_pkg.sv
// Shared widths and response record for the register-file read arbiter slice.
package regfile_read_arbiter_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REQ   = 4;
  localparam int TAG_W     = 4;
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
  } resp_t;
endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Request/response bus between the issue requesters and the read arbiter.
interface regfile_read_arbiter_if
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = regfile_read_arbiter_pkg::NUM_REQ,
  parameter int TAG_W   = regfile_read_arbiter_pkg::TAG_W
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][REG_IDX_W-1:0] req_rs1;
  logic [NUM_REQ-1:0][REG_IDX_W-1:0] req_rs2;
  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag;

  logic             resp_valid;
  logic             resp_ready;
  logic [SEL_W-1:0] resp_id;
  logic [TAG_W-1:0] resp_tag;
  logic [XLEN-1:0]  resp_rs1_data;
  logic [XLEN-1:0]  resp_rs2_data;

  modport master (
    output req_valid, req_rs1, req_rs2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_tag, resp_rs1_data, resp_rs2_data
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_id, resp_tag, resp_rs1_data, resp_rs2_data
  );
endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read-port pair among NUM_REQ issue requesters,
// forwarding the commit-stage write and returning one registered response.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = regfile_read_arbiter_pkg::NUM_REQ,
  parameter int TAG_W   = regfile_read_arbiter_pkg::TAG_W
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_read_arbiter_if.slave bus,
  output logic [REG_IDX_W-1:0] rf_rs1,
  output logic [REG_IDX_W-1:0] rf_rs2,
  input  logic [XLEN-1:0]      rf_rs1_data,
  input  logic [XLEN-1:0]      rf_rs2_data,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [SEL_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic                 stall;
  logic                 gnt_any;
  logic [SEL_W-1:0]     gnt_id;
  resp_t                resp_p1;
  logic [REG_IDX_W-1:0] rs1_idx_p1;
  logic [REG_IDX_W-1:0] rs2_idx_p1;

  function automatic logic wb_hit(input logic [REG_IDX_W-1:0] idx);
    return wb_we && (wb_rd != '0) && (wb_rd == idx);
  endfunction

  function automatic logic [XLEN-1:0] fwd_operand(input logic [REG_IDX_W-1:0] idx,
                                                  input logic [XLEN-1:0]      rf_data);
    if (idx == '0)  return '0;
    if (wb_hit(idx)) return wb_data;
    return rf_data;
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(SEL_W)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Stage p0: grant selection and register-file address drive
  always_comb begin
    stall         = resp_p1.valid && !bus.resp_ready;
    bus.req_ready = (!reset && !flush && !stall) ? grant : '0;
    gnt_any       = |bus.req_ready;
    gnt_id        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ready[i]) gnt_id = SEL_W'(i);
    end
    rf_rs1 = '0;
    rf_rs2 = '0;
    if (gnt_any) begin
      rf_rs1 = bus.req_rs1[gnt_id];
      rf_rs2 = bus.req_rs2[gnt_id];
    end
  end

  // Stage p1: response register; a held response keeps snooping the write port
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      resp_p1    <= '0;
      rs1_idx_p1 <= '0;
      rs2_idx_p1 <= '0;
    end else if (flush) begin
      resp_p1.valid <= 1'b0;
    end else if (stall) begin
      if (wb_hit(rs1_idx_p1)) resp_p1.rs1_data <= wb_data;
      if (wb_hit(rs2_idx_p1)) resp_p1.rs2_data <= wb_data;
    end else begin
      resp_p1.valid <= gnt_any;
      if (gnt_any) begin
        resp_p1.id       <= gnt_id;
        resp_p1.tag      <= bus.req_tag[gnt_id];
        resp_p1.rs1_data <= fwd_operand(rf_rs1, rf_rs1_data);
        resp_p1.rs2_data <= fwd_operand(rf_rs2, rf_rs2_data);
        rs1_idx_p1       <= rf_rs1;
        rs2_idx_p1       <= rf_rs2;
        rr_ptr           <= (gnt_id == SEL_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  assign bus.resp_valid    = resp_p1.valid;
  assign bus.resp_id       = resp_p1.id;
  assign bus.resp_tag      = resp_p1.tag;
  assign bus.resp_rs1_data = resp_p1.rs1_data;
  assign bus.resp_rs2_data = resp_p1.rs2_data;
endmodule
